// File: rtl/stb_pkg.sv
// Shared types and default sizes for the trace capture unit.
package stb_pkg;

    localparam int unsigned STB_WIDTH      = 64;
    localparam int unsigned STB_MAX_TRACES = 8;

    typedef enum logic {
        trace_mode  = 1'b0,
        stream_mode = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ARMED,
        TRIGGERED,
        DONE
    } trg_state_e;

endpackage

// File: rtl/trace_capture_unit_if.sv
// Store handshake towards the memory side: one word offered, held until accepted.
interface trace_capture_unit_if
    import stb_pkg::*;
#(
    parameter int unsigned WIDTH = STB_WIDTH
);

    logic [WIDTH-1:0] DATA_O;
    logic             STORE_O;
    logic             STORE_PERM_I;

    modport master (output DATA_O, output STORE_O, input STORE_PERM_I);
    modport slave  (input DATA_O, input STORE_O, output STORE_PERM_I);

endinterface

// File: rtl/trace_trigger_unit.sv
// Pattern/edge trigger, ARMED->TRIGGERED->DONE sequencing, post-trigger delay
// counter and the latched event position/word.
module trace_trigger_unit
    import stb_pkg::*;
#(
    parameter int unsigned MAX_TRACES = STB_MAX_TRACES,
    parameter int unsigned POS_W      = 6,
    parameter int unsigned DELAY_W    = 16,
    parameter int unsigned WCNT_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  accept_i,
    input  logic [MAX_TRACES-1:0] lane_mask_i,
    input  logic [MAX_TRACES-1:0] trace_i,
    input  logic                  trig_i,
    input  logic [MAX_TRACES-1:0] mask_i,
    input  logic [MAX_TRACES-1:0] value_i,
    input  logic                  edge_i,
    input  logic [DELAY_W-1:0]    delay_i,
    input  logic [POS_W-1:0]      pos_i,
    input  logic [WCNT_W-1:0]     wcnt_i,
    output logic                  done_o,
    output logic                  trg_event_o,
    output logic                  trg_delayed_o,
    output logic [POS_W-1:0]      event_pos_o,
    output logic [WCNT_W-1:0]     event_word_o
);

    trg_state_e            state_q, state_d;
    logic [DELAY_W-1:0]    cnt_q, cnt_d;
    logic                  prev_q, prev_d;
    logic                  evt_q, evt_d;
    logic [POS_W-1:0]      evpos_q, evpos_d;
    logic [WCNT_W-1:0]     evword_q, evword_d;

    logic [MAX_TRACES-1:0] active_mask;
    logic                  match;
    logic                  fire;
    logic [DELAY_W-1:0]    cnt_inc;

    assign active_mask = mask_i & lane_mask_i;
    assign match       = (|active_mask) & ((trace_i & active_mask) == (value_i & active_mask));
    assign fire        = trig_i | (match & ~(edge_i & prev_q));
    assign cnt_inc     = cnt_q + 1'b1;

    // Next-state: trigger detection on accepted samples and delay counting.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        evt_d    = evt_q;
        evpos_d  = evpos_q;
        evword_d = evword_q;
        if (accept_i) begin
            prev_d = match;
            case (state_q)
                ARMED: begin
                    if (fire) begin
                        evt_d    = 1'b1;
                        evpos_d  = pos_i;
                        evword_d = wcnt_i;
                        cnt_d    = DELAY_W'(1);
                        // The trigger sample itself counts, so delays 0 and 1 finish at once.
                        state_d  = (delay_i <= DELAY_W'(1)) ? DONE : TRIGGERED;
                    end
                end
                TRIGGERED: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= delay_i) begin
                        state_d = DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State and event latches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARMED;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            evt_q    <= 1'b0;
            evpos_q  <= '0;
            evword_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            evt_q    <= evt_d;
            evpos_q  <= evpos_d;
            evword_q <= evword_d;
        end
    end

    assign done_o        = (state_q == DONE);
    assign trg_delayed_o = (state_q == DONE);
    assign trg_event_o   = evt_q;
    assign event_pos_o   = evpos_q;
    assign event_word_o  = evword_q;

endmodule

// File: rtl/trace_capture_unit.sv
// Trace packer: decimated sampling of 2**NTRACE_I lanes into WIDTH-bit words,
// double-buffered store handshake, drop counter and trigger sequencing.
module trace_capture_unit
    import stb_pkg::*;
#(
    parameter int unsigned WIDTH      = STB_WIDTH,
    parameter int unsigned MAX_TRACES = STB_MAX_TRACES,
    parameter int unsigned NTRACE_W   = 2,
    parameter int unsigned DECIM_W    = 8,
    parameter int unsigned DELAY_W    = 16,
    parameter int unsigned WCNT_W     = 16
) (
    input  logic                     FPGA_CLK_I,
    input  logic                     RST_I,
    input  logic                     MODE_I,
    input  logic [NTRACE_W-1:0]      NTRACE_I,
    input  logic [DECIM_W-1:0]       DECIM_I,
    input  logic [MAX_TRACES-1:0]    TRG_MASK_I,
    input  logic [MAX_TRACES-1:0]    TRG_VALUE_I,
    input  logic                     TRG_EDGE_I,
    input  logic [DELAY_W-1:0]       TRG_DELAY_I,
    input  logic                     FPGA_TRIG_I,
    input  logic [MAX_TRACES-1:0]    FPGA_TRACE_I,
    output logic                     FPGA_WRITE_READY_O,
    trace_capture_unit_if.master     mem,
    output logic                     TRG_EVENT_O,
    output logic                     TRG_DELAYED_O,
    output logic [$clog2(WIDTH)-1:0] EVENT_POS_O,
    output logic [WCNT_W-1:0]        EVENT_WORD_O,
    output logic [15:0]              DROP_CNT_O
);

    localparam int unsigned POS_W = $clog2(WIDTH);

    mode_e                 mode;
    logic                  started_q;
    logic [DECIM_W-1:0]    dcnt_q, dcnt_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [WIDTH-1:0]      pack_q, pack_d;
    logic [WIDTH-1:0]      out_q, out_d;
    logic                  store_q, store_d;
    logic                  full_q, full_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [15:0]           drop_q, drop_d;

    logic [POS_W:0]        n_lanes;
    logic [POS_W:0]        pos_sum;
    logic [MAX_TRACES-1:0] lane_mask;
    logic [WIDTH-1:0]      sample_wide;
    logic [WIDTH-1:0]      mask_wide;
    logic                  tick;
    logic                  accept;
    logic                  wrap;
    logic                  drain;
    logic                  out_free;
    logic                  trg_done;

    assign mode        = mode_e'(MODE_I);
    assign n_lanes     = (POS_W+1)'(1) << NTRACE_I;
    assign lane_mask   = ~({MAX_TRACES{1'b1}} << n_lanes);
    assign sample_wide = WIDTH'(FPGA_TRACE_I & lane_mask) << pos_q;
    assign mask_wide   = WIDTH'(lane_mask) << pos_q;
    assign pos_sum     = {1'b0, pos_q} + n_lanes;
    assign wrap        = pos_sum[POS_W];

    assign tick     = started_q & (dcnt_q == DECIM_I);
    assign accept   = tick & ~full_q & ~trg_done & ((mode == trace_mode) | FPGA_TRIG_I);
    assign drain    = store_q & mem.STORE_PERM_I;
    assign out_free = ~store_q | mem.STORE_PERM_I;

    // Datapath next-state: decimation, packing, out-register hand-off, counters.
    always_comb begin
        dcnt_d  = dcnt_q;
        pos_d   = pos_q;
        pack_d  = pack_q;
        out_d   = out_q;
        store_d = drain ? 1'b0 : store_q;
        full_d  = full_q;
        wcnt_d  = wcnt_q + WCNT_W'(drain);
        drop_d  = drop_q;

        if (started_q) begin
            dcnt_d = tick ? '0 : dcnt_q + 1'b1;
        end

        if (accept) begin
            pack_d = (pack_q & ~mask_wide) | sample_wide;
            pos_d  = pos_sum[POS_W-1:0];
        end

        // A held full pack has priority; it only exists while the out word is pending.
        if (full_q & out_free) begin
            out_d   = pack_q;
            store_d = 1'b1;
            full_d  = 1'b0;
        end else if (accept & wrap) begin
            if (out_free) begin
                out_d   = pack_d;
                store_d = 1'b1;
            end else begin
                full_d  = 1'b1;
            end
        end

        if (tick & full_q & (mode == trace_mode) & ~trg_done & ~(&drop_q)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge FPGA_CLK_I) begin
        if (RST_I) begin
            started_q <= 1'b0;
            dcnt_q    <= '0;
            pos_q     <= '0;
            pack_q    <= '0;
            out_q     <= '0;
            store_q   <= 1'b0;
            full_q    <= 1'b0;
            wcnt_q    <= '0;
            drop_q    <= '0;
        end else begin
            started_q <= 1'b1;
            dcnt_q    <= dcnt_d;
            pos_q     <= pos_d;
            pack_q    <= pack_d;
            out_q     <= out_d;
            store_q   <= store_d;
            full_q    <= full_d;
            wcnt_q    <= wcnt_d;
            drop_q    <= drop_d;
        end
    end

    trace_trigger_unit #(
        .MAX_TRACES (MAX_TRACES),
        .POS_W      (POS_W),
        .DELAY_W    (DELAY_W),
        .WCNT_W     (WCNT_W)
    ) u_trigger (
        .clk_i         (FPGA_CLK_I),
        .rst_i         (RST_I),
        .accept_i      (accept & (mode == trace_mode)),
        .lane_mask_i   (lane_mask),
        .trace_i       (FPGA_TRACE_I),
        .trig_i        (FPGA_TRIG_I),
        .mask_i        (TRG_MASK_I),
        .value_i       (TRG_VALUE_I),
        .edge_i        (TRG_EDGE_I),
        .delay_i       (TRG_DELAY_I),
        .pos_i         (pos_q),
        .wcnt_i        (wcnt_q),
        .done_o        (trg_done),
        .trg_event_o   (TRG_EVENT_O),
        .trg_delayed_o (TRG_DELAYED_O),
        .event_pos_o   (EVENT_POS_O),
        .event_word_o  (EVENT_WORD_O)
    );

    assign FPGA_WRITE_READY_O = ~full_q;
    assign mem.DATA_O         = out_q;
    assign mem.STORE_O        = store_q;
    assign DROP_CNT_O         = drop_q;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Bench for trace_capture_unit: directed scenarios plus randomized runs,
// all checked against a queue-based reference model.
module tb_trace_capture_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  ntrace;
    logic [7:0]  decim;
    logic [7:0]  mask;
    logic [7:0]  value;
    logic        trg_edge;
    logic [15:0] delay;
    logic        trig;
    logic [7:0]  trace;
    logic        wready;
    logic        evt;
    logic        delayed;
    logic [5:0]  evpos;
    logic [15:0] evword;
    logic [15:0] drop;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    trace_capture_unit_if #(.WIDTH(64)) mem_if ();

    trace_capture_unit #(
        .WIDTH      (64),
        .MAX_TRACES (8),
        .NTRACE_W   (2),
        .DECIM_W    (8),
        .DELAY_W    (16),
        .WCNT_W     (16)
    ) dut (
        .FPGA_CLK_I         (clk),
        .RST_I              (rst),
        .MODE_I             (mode),
        .NTRACE_I           (ntrace),
        .DECIM_I            (decim),
        .TRG_MASK_I         (mask),
        .TRG_VALUE_I        (value),
        .TRG_EDGE_I         (trg_edge),
        .TRG_DELAY_I        (delay),
        .FPGA_TRIG_I        (trig),
        .FPGA_TRACE_I       (trace),
        .FPGA_WRITE_READY_O (wready),
        .mem                (mem_if),
        .TRG_EVENT_O        (evt),
        .TRG_DELAYED_O      (delayed),
        .EVENT_POS_O        (evpos),
        .EVENT_WORD_O       (evword),
        .DROP_CNT_O         (drop)
    );

    always #5 clk = ~clk;

    // Reference model: pending words are a queue (front = offered word,
    // second entry = completed word waiting for room).
    logic [63:0] m_q[$];
    logic [63:0] m_word;
    int m_live, m_since, m_pos, m_wcnt, m_drop;
    int m_st, m_cnt, m_prev, m_evt, m_evpos, m_evword;

    function automatic logic exp_store();
        return m_q.size() > 0;
    endfunction

    function automatic logic exp_ready();
        return m_q.size() < 2;
    endfunction

    task automatic model_edge();
        int n;
        logic tick, stall, drain, acc, wrapped, match, fire;
        logic [7:0] lanes, am;
        logic [63:0] wword;
        if (rst) begin
            m_live = 0; m_since = 0; m_pos = 0; m_word = '0; m_q.delete();
            m_wcnt = 0; m_drop = 0; m_st = 0; m_cnt = 0; m_prev = 0;
            m_evt = 0; m_evpos = 0; m_evword = 0;
            return;
        end
        if (m_live == 0) begin
            m_live = 1;
            return;
        end
        tick = (m_since % (int'(decim) + 1)) == int'(decim);
        m_since++;
        n = 1 << ntrace;
        stall = (m_q.size() == 2);
        drain = (m_q.size() > 0) && mem_if.STORE_PERM_I;
        acc = tick && !stall && (m_st != 2) && (mode == 1'b0 || trig);
        if (tick && stall && mode == 1'b0 && m_st != 2 && m_drop < 65535) m_drop++;
        wrapped = 1'b0;
        wword = '0;
        if (acc) begin
            if (mode == 1'b0) begin
                lanes = (n == 8) ? 8'hFF : 8'((1 << n) - 1);
                am = mask & lanes;
                match = (am != 0) && ((trace & am) == (value & am));
                fire = trig || (match && !(trg_edge && m_prev != 0));
                m_prev = match ? 1 : 0;
                if (m_st == 0 && fire) begin
                    m_evt = 1; m_evpos = m_pos; m_evword = m_wcnt; m_cnt = 1;
                    m_st = (delay <= 1) ? 2 : 1;
                end else if (m_st == 1) begin
                    m_cnt++;
                    if (m_cnt >= int'(delay)) m_st = 2;
                end
            end
            for (int b = 0; b < n; b++) m_word[m_pos + b] = trace[b];
            m_pos += n;
            if (m_pos == 64) begin
                wrapped = 1'b1; wword = m_word; m_pos = 0;
            end
        end
        if (drain) begin
            void'(m_q.pop_front());
            m_wcnt = (m_wcnt + 1) % 65536;
        end
        if (wrapped) m_q.push_back(wword);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        mode = 0; ntrace = 3; decim = 0; mask = 0; value = 0; trg_edge = 0;
        delay = 0; trig = 0; trace = 0; mem_if.STORE_PERM_I = 1'b1;
        do_reset();
        checks++; if (mem_if.STORE_O !== 1'b0) begin failures++; $display("FAIL rst_store got=%b exp=0", mem_if.STORE_O); end
        checks++; if (mem_if.DATA_O !== 64'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", mem_if.DATA_O); end
        checks++; if (wready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", wready); end
        checks++; if ({evt, delayed} !== 2'b00) begin failures++; $display("FAIL rst_trg got=%b exp=00", {evt, delayed}); end
        checks++; if ({evpos, evword, drop} !== 38'h0) begin failures++; $display("FAIL rst_cnt got=%h exp=0", {evpos, evword, drop}); end
    endtask

    task automatic test_ramp();
        logic [63:0] words[$];
        int at[$];
        int s;
        mode = 0; ntrace = 3; decim = 0; mask = 0; value = 0; trg_edge = 0;
        delay = 0; trig = 0; mem_if.STORE_PERM_I = 1'b1;
        do_reset();
        for (int j = 1; j <= 18; j++) begin
            s = j - 2;
            if (s >= 0 && s < 8) trace = 8'(8'h38 + s);
            else if (s >= 8 && s < 16) trace = 8'(8'h30 + s - 8);
            else trace = 8'h00;
            step();
            checks++; if (mem_if.STORE_O !== exp_store()) begin failures++; $display("FAIL ramp_store cyc=%0d got=%b exp=%b", cyc, mem_if.STORE_O, exp_store()); end
            if (mem_if.STORE_O === 1'b1) begin words.push_back(mem_if.DATA_O); at.push_back(cyc); end
        end
        checks++;
        if (words.size() != 2) begin
            failures++; $display("FAIL ramp_count got=%0d exp=2", words.size());
        end else begin
            checks++; if (words[0] !== 64'h3f3e3d3c3b3a3938) begin failures++; $display("FAIL ramp_w0 got=%h exp=3f3e3d3c3b3a3938", words[0]); end
            checks++; if (words[1] !== 64'h3736353433323130) begin failures++; $display("FAIL ramp_w1 got=%h exp=3736353433323130", words[1]); end
            checks++; if (at[1] - at[0] != 8) begin failures++; $display("FAIL ramp_gap got=%0d exp=8", at[1] - at[0]); end
        end
        checks++; if (drop !== 16'd0) begin failures++; $display("FAIL ramp_drop got=%0d exp=0", drop); end
    endtask

    task automatic test_stall();
        int saw_stall;
        saw_stall = 0;
        mode = 0; ntrace = 3; decim = 0; mask = 0; trig = 0; mem_if.STORE_PERM_I = 1'b0;
        do_reset();
        for (int j = 1; j <= 40; j++) begin
            trace = 8'($urandom);
            mem_if.STORE_PERM_I = (j > 20);
            step();
            if (wready === 1'b0) saw_stall = 1;
            checks++; if (mem_if.STORE_O !== exp_store()) begin failures++; $display("FAIL stall_store cyc=%0d got=%b exp=%b", cyc, mem_if.STORE_O, exp_store()); end
            checks++; if (wready !== exp_ready()) begin failures++; $display("FAIL stall_ready cyc=%0d got=%b exp=%b", cyc, wready, exp_ready()); end
            if (exp_store()) begin
                checks++; if (mem_if.DATA_O !== m_q[0]) begin failures++; $display("FAIL stall_data cyc=%0d got=%h exp=%h", cyc, mem_if.DATA_O, m_q[0]); end
            end
        end
        checks++; if (saw_stall != 1) begin failures++; $display("FAIL stall_seen got=%0d exp=1", saw_stall); end
        checks++; if (drop !== 16'(m_drop)) begin failures++; $display("FAIL stall_drop got=%0d exp=%0d", drop, m_drop); end
    endtask

    task automatic test_decim();
        int first;
        first = -1;
        mode = 0; ntrace = 0; decim = 3; mask = 0; trig = 0; mem_if.STORE_PERM_I = 1'b1;
        do_reset();
        for (int j = 1; j <= 300; j++) begin
            trace = 8'($urandom);
            step();
            if (mem_if.STORE_O === 1'b1 && first < 0) first = cyc;
            checks++; if (mem_if.STORE_O !== exp_store()) begin failures++; $display("FAIL decim_store cyc=%0d got=%b exp=%b", cyc, mem_if.STORE_O, exp_store()); end
            if (exp_store()) begin
                checks++; if (mem_if.DATA_O !== m_q[0]) begin failures++; $display("FAIL decim_data cyc=%0d got=%h exp=%h", cyc, mem_if.DATA_O, m_q[0]); end
            end
        end
        checks++; if (first != 257) begin failures++; $display("FAIL decim_first got=%0d exp=257", first); end
    endtask

    task automatic test_trigger();
        int stores, s;
        logic [7:0] v;
        stores = 0;
        mode = 0; ntrace = 3; decim = 0; mask = 8'h0F; value = 8'h05; trg_edge = 1;
        delay = 16'd10; trig = 0; mem_if.STORE_PERM_I = 1'b1;
        do_reset();
        for (int j = 1; j <= 40; j++) begin
            s = j - 2;
            v = 8'($urandom);
            if (s < 13) begin
                if (v[3:0] == 4'h5) v[0] = ~v[0];
            end else begin
                v[3:0] = 4'h5;
            end
            trace = v;
            step();
            if (mem_if.STORE_O === 1'b1) stores++;
            checks++; if (evt !== 1'(m_evt)) begin failures++; $display("FAIL trg_event cyc=%0d got=%b exp=%0d", cyc, evt, m_evt); end
            checks++; if (delayed !== (m_st == 2)) begin failures++; $display("FAIL trg_delayed cyc=%0d got=%b exp=%b", cyc, delayed, (m_st == 2)); end
        end
        checks++; if (evpos !== 6'd40) begin failures++; $display("FAIL trg_pos got=%0d exp=40", evpos); end
        checks++; if (evword !== 16'd1) begin failures++; $display("FAIL trg_word got=%0d exp=1", evword); end
        checks++; if (delayed !== 1'b1) begin failures++; $display("FAIL trg_done got=%b exp=1", delayed); end
        checks++; if (stores != 2) begin failures++; $display("FAIL trg_stores got=%0d exp=2", stores); end
    endtask

    task automatic test_stream();
        int first;
        first = -1;
        mode = 1; ntrace = 3; decim = 0; mask = 8'h0F; value = 8'h00; trg_edge = 0;
        delay = 0; mem_if.STORE_PERM_I = 1'b1;
        do_reset();
        for (int j = 1; j <= 30; j++) begin
            trig = (j % 2 == 0);
            trace = 8'($urandom) & 8'hF0;
            step();
            if (mem_if.STORE_O === 1'b1 && first < 0) first = cyc;
            checks++; if (mem_if.STORE_O !== exp_store()) begin failures++; $display("FAIL stream_store cyc=%0d got=%b exp=%b", cyc, mem_if.STORE_O, exp_store()); end
            if (exp_store()) begin
                checks++; if (mem_if.DATA_O !== m_q[0]) begin failures++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, mem_if.DATA_O, m_q[0]); end
            end
        end
        checks++; if (first != 16) begin failures++; $display("FAIL stream_first got=%0d exp=16", first); end
        checks++; if ({evt, delayed} !== 2'b00) begin failures++; $display("FAIL stream_trg got=%b exp=00", {evt, delayed}); end
        checks++; if (drop !== 16'd0) begin failures++; $display("FAIL stream_drop got=%0d exp=0", drop); end
        trig = 0;
    endtask

    task automatic test_reset_mid();
        mode = 0; ntrace = 3; decim = 0; mask = 0; trig = 0; mem_if.STORE_PERM_I = 1'b0;
        do_reset();
        for (int j = 1; j <= 13; j++) begin
            trace = 8'($urandom);
            step();
        end
        checks++; if (mem_if.STORE_O !== 1'b1) begin failures++; $display("FAIL mid_pre_store got=%b exp=1", mem_if.STORE_O); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        checks++; if (mem_if.STORE_O !== 1'b0) begin failures++; $display("FAIL mid_store got=%b exp=0", mem_if.STORE_O); end
        checks++; if (mem_if.DATA_O !== 64'h0) begin failures++; $display("FAIL mid_data got=%h exp=0", mem_if.DATA_O); end
        checks++; if (wready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", wready); end
        mem_if.STORE_PERM_I = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            trace = 8'($urandom);
            step();
            checks++; if (mem_if.STORE_O !== exp_store()) begin failures++; $display("FAIL mid_post_store cyc=%0d got=%b exp=%b", cyc, mem_if.STORE_O, exp_store()); end
            if (exp_store()) begin
                checks++; if (mem_if.DATA_O !== m_q[0]) begin failures++; $display("FAIL mid_post_data cyc=%0d got=%h exp=%h", cyc, mem_if.DATA_O, m_q[0]); end
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            mode = 1'($urandom_range(0, 1));
            ntrace = 2'($urandom_range(0, 3));
            decim = 8'($urandom_range(0, 2));
            mask = 8'($urandom_range(0, 3)) == 0 ? 8'h00 : 8'($urandom);
            value = 8'($urandom);
            trg_edge = 1'($urandom_range(0, 1));
            delay = 16'($urandom_range(0, 20));
            do_reset();
            for (int j = 1; j <= 300; j++) begin
                trace = 8'($urandom);
                trig = ($urandom_range(0, 9) == 0) || (mode && $urandom_range(0, 1) == 1);
                mem_if.STORE_PERM_I = ($urandom_range(0, 3) != 0);
                step();
                checks++; if (mem_if.STORE_O !== exp_store()) begin failures++; $display("FAIL rnd_store r=%0d cyc=%0d got=%b exp=%b", r, cyc, mem_if.STORE_O, exp_store()); end
                checks++; if (wready !== exp_ready()) begin failures++; $display("FAIL rnd_ready r=%0d cyc=%0d got=%b exp=%b", r, cyc, wready, exp_ready()); end
                if (exp_store()) begin
                    checks++; if (mem_if.DATA_O !== m_q[0]) begin failures++; $display("FAIL rnd_data r=%0d cyc=%0d got=%h exp=%h", r, cyc, mem_if.DATA_O, m_q[0]); end
                end
                checks++; if (drop !== 16'(m_drop)) begin failures++; $display("FAIL rnd_drop r=%0d cyc=%0d got=%0d exp=%0d", r, cyc, drop, m_drop); end
                checks++; if ({evt, delayed} !== {1'(m_evt), (m_st == 2)}) begin failures++; $display("FAIL rnd_trg r=%0d cyc=%0d got=%b exp=%b", r, cyc, {evt, delayed}, {1'(m_evt), (m_st == 2)}); end
                if (m_evt != 0) begin
                    checks++; if ({evpos, evword} !== {6'(m_evpos), 16'(m_evword)}) begin failures++; $display("FAIL rnd_evloc r=%0d cyc=%0d got=%h exp=%h", r, cyc, {evpos, evword}, {6'(m_evpos), 16'(m_evword)}); end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        trace = 8'h00;
        test_reset();
        test_ramp();
        test_stall();
        test_decim();
        test_trigger();
        test_stream();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
